// File: rtl/framebuffer_pingpong_ram.sv
// Double-buffered pixel frame store. The writer fills the back bank while scan-out reads the
// front bank; the banks exchange roles only when a frame completes on both sides.
module framebuffer_pingpong_ram #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned DEPTH    = 102400,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                wr_en,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                wr_ready,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   input  logic                rd_frame_end,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic                front_sel
);

   localparam int              NumBe  = DATA_W / 8;
   localparam int unsigned     IdxW   = $clog2(2 * DEPTH);
   localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {StIdle, StPending} swap_st_e;

   // Bank 0 occupies words [0, DEPTH), bank 1 occupies [DEPTH, 2*DEPTH).
   logic [DATA_W-1:0] mem_q [2*DEPTH];

   swap_st_e          st_q, st_d;
   logic              front_sel_q, front_sel_d;
   logic              swap_ack_q, swap_ack_d;
   logic              swap;
   logic              wr_ok;
   logic              rd_in_range;
   logic [IdxW-1:0]   wr_idx, rd_idx;
   logic              rd_valid1_q, rd_valid1_d;
   logic [DATA_W-1:0] rd_data1_q, rd_data1_d;

   // Address decode: writes land in the back bank, reads come from the front bank.
   always_comb begin
      wr_ready    = (st_q == StIdle);
      wr_ok       = wr_en && wr_ready && ({1'b0, wr_addr} < DepthA);
      rd_in_range = ({1'b0, rd_addr} < DepthA);
      wr_idx      = IdxW'(wr_addr) + (front_sel_q ? '0 : IdxW'(DEPTH));
      rd_idx      = IdxW'(rd_addr) + (front_sel_q ? IdxW'(DEPTH) : '0);
   end

   // Byte-lane writes into the back bank; storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int i = 0; i < NumBe; i++) begin
            if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // First read stage: sample the front bank; data holds when no read is issued.
   always_comb begin
      rd_valid1_d = rd_en;
      rd_data1_d  = rd_data1_q;
      if (rd_en) rd_data1_d = rd_in_range ? mem_q[rd_idx] : '0;
   end

   // First read stage registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_valid1_q <= 1'b0;
         rd_data1_q  <= '0;
      end else begin
         rd_valid1_q <= rd_valid1_d;
         rd_data1_q  <= rd_data1_d;
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic              rd_valid2_q, rd_valid2_d;
      logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

      // Extra output register: forward stage-1 results, otherwise hold.
      always_comb begin
         rd_valid2_d = rd_valid1_q;
         rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
      end

      // Output register stage.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            rd_valid2_q <= 1'b0;
            rd_data2_q  <= '0;
         end else begin
            rd_valid2_q <= rd_valid2_d;
            rd_data2_q  <= rd_data2_d;
         end
      end

      assign rd_valid = rd_valid2_q;
      assign rd_data  = rd_data2_q;
   end else begin : g_lat1
      assign rd_valid = rd_valid1_q;
      assign rd_data  = rd_data1_q;
   end

   // Swap FSM: a swap needs both a finished back frame and the end of scan-out.
   always_comb begin
      st_d = st_q;
      swap = 1'b0;
      case (st_q)
         StIdle: begin
            if (swap_req) begin
               if (rd_frame_end) swap = 1'b1;
               else              st_d = StPending;
            end
         end
         StPending: begin
            // Repeated swap_req pulses are ignored here.
            if (rd_frame_end) begin
               swap = 1'b1;
               st_d = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase
      front_sel_d = front_sel_q ^ swap;
      swap_ack_d  = swap;
   end

   // Swap FSM and bank-select registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         st_q        <= StIdle;
         front_sel_q <= 1'b0;
         swap_ack_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         front_sel_q <= front_sel_d;
         swap_ack_q  <= swap_ack_d;
      end
   end

   assign swap_ack  = swap_ack_q;
   assign front_sel = front_sel_q;

endmodule

// File: tb/tb_framebuffer_pingpong_ram.sv
// Bench for framebuffer_pingpong_ram: two instances (read latency 1 and 2) share one stimulus
// stream and are compared each cycle against a frame-level model of the two banks.
module tb_framebuffer_pingpong_ram;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        wr_en, rd_en, rd_frame_end, swap_req;
   logic [2:0]  wr_be;
   logic [4:0]  wr_addr, rd_addr;
   logic [23:0] wr_data;

   logic        wr_ready1, rd_valid1, swap_ack1, front_sel1;
   logic        wr_ready2, rd_valid2, swap_ack2, front_sel2;
   logic [23:0] rd_data1, rd_data2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [23:0] mem_m [2][16];
   int          front_m;
   bit          pend_m;
   bit          ack_m;
   bit          v1_m, v2_m;
   logic [23:0] d1_m, d2_m;

   always #5 clk = ~clk;

   framebuffer_pingpong_ram #(.DATA_W(24), .DEPTH(16), .ADDR_W(5), .READ_LAT(1)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_frame_end(rd_frame_end),
      .swap_req(swap_req), .swap_ack(swap_ack1), .front_sel(front_sel1)
   );

   framebuffer_pingpong_ram #(.DATA_W(24), .DEPTH(16), .ADDR_W(5), .READ_LAT(2)) u_dut2 (
      .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready2), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_frame_end(rd_frame_end),
      .swap_req(swap_req), .swap_ack(swap_ack2), .front_sel(front_sel2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all();
      chk("front_sel1", {31'b0, front_sel1}, front_m);
      chk("front_sel2", {31'b0, front_sel2}, front_m);
      chk("swap_ack1", {31'b0, swap_ack1}, {31'b0, ack_m});
      chk("swap_ack2", {31'b0, swap_ack2}, {31'b0, ack_m});
      chk("wr_ready1", {31'b0, wr_ready1}, {31'b0, !pend_m});
      chk("wr_ready2", {31'b0, wr_ready2}, {31'b0, !pend_m});
      chk("rd_valid1", {31'b0, rd_valid1}, {31'b0, v1_m});
      chk("rd_data1", {8'b0, rd_data1}, {8'b0, d1_m});
      chk("rd_valid2", {31'b0, rd_valid2}, {31'b0, v2_m});
      chk("rd_data2", {8'b0, rd_data2}, {8'b0, d2_m});
   endtask

   task automatic clr();
      wr_en = 0; rd_en = 0; rd_frame_end = 0; swap_req = 0;
      wr_be = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
   endtask

   // One clock edge: apply frame-level rules to the model, then compare both instances.
   task automatic step();
      bit          rv, pv1;
      logic [23:0] rdv, pd1;
      int          back;
      rv   = rd_en;
      rdv  = (rd_addr < 16) ? mem_m[front_m][rd_addr[3:0]] : 24'h0;
      back = 1 - front_m;
      if (wr_en && !pend_m && wr_addr < 16) begin
         for (int i = 0; i < 3; i++)
            if (wr_be[i]) mem_m[back][wr_addr[3:0]][8*i +: 8] = wr_data[8*i +: 8];
      end
      ack_m = rd_frame_end && (pend_m || swap_req);
      pend_m = pend_m ? !rd_frame_end : (swap_req && !rd_frame_end);
      if (ack_m) front_m = 1 - front_m;
      // Latency-2 output shows the read issued one cycle before the latency-1 output.
      pv1 = v1_m; pd1 = d1_m;
      v1_m = rv;  if (rv)  d1_m = rdv;
      v2_m = pv1; if (pv1) d2_m = pd1;
      @(posedge clk); #1;
      chk_all();
   endtask

   task automatic idle(input int n);
      clr();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [4:0] a, input logic [23:0] d, input logic [2:0] be);
      clr(); wr_en = 1; wr_addr = a; wr_data = d; wr_be = be; step(); clr();
   endtask

   task automatic rd(input logic [4:0] a);
      clr(); rd_en = 1; rd_addr = a; step(); clr();
   endtask

   task automatic swap_now();
      clr(); swap_req = 1; rd_frame_end = 1; step(); clr();
   endtask

   task automatic do_reset();
      clr();
      n_rst = 0; #1;
      front_m = 0; pend_m = 0; ack_m = 0;
      v1_m = 0; v2_m = 0; d1_m = '0; d2_m = '0;
      chk_all();
      @(posedge clk); #1;
      n_rst = 1;
   endtask

   initial begin
      clr();
      for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) mem_m[b][a] = '0;
      n_rst = 1; #2;
      do_reset();
      idle(1);

      // Fill both banks so every later read has a defined value.
      for (int a = 0; a < 16; a++) wr(5'(a), 24'($urandom), 3'b111);
      swap_now();
      for (int a = 0; a < 16; a++) wr(5'(a), 24'($urandom), 3'b111);
      swap_now();
      idle(1);

      // Write, swap on a frame boundary, then read back from the new front bank.
      wr(5'd3, 24'hA1B2C3, 3'b111);
      swap_now();
      chk("t1_swap_ack", {31'b0, swap_ack1}, 32'd1);
      rd(5'd3);
      chk("t1_front", {31'b0, front_sel1}, 32'd1);
      chk("t1_data", {8'b0, rd_data1}, 32'hA1B2C3);
      chk("t1_valid", {31'b0, rd_valid1}, 32'd1);
      idle(2);

      // Single byte-lane merge.
      wr(5'd5, 24'h112233, 3'b111);
      wr(5'd5, 24'hFFFFFF, 3'b010);
      swap_now();
      rd(5'd5);
      idle(1);
      chk("t2_merge", {8'b0, rd_data2}, 32'h11FF33);

      // Deferred swap: writes are blocked while waiting for the frame end.
      clr(); swap_req = 1; step();
      chk("t3_wr_ready", {31'b0, wr_ready1}, 32'd0);
      wr(5'd0, 24'h777777, 3'b111);
      clr(); swap_req = 1; step();
      idle(2);
      clr(); rd_frame_end = 1; step();
      chk("t3_ready_back", {31'b0, wr_ready1}, 32'd1);
      rd(5'd0);
      idle(2);

      // Back-to-back reads through the two-stage pipeline.
      for (int a = 0; a < 8; a++) begin
         clr(); rd_en = 1; rd_addr = 5'(a); step();
      end
      idle(3);

      // Out-of-range read and write.
      rd(5'd20);
      chk("t5_oor_data", {8'b0, rd_data1}, 32'd0);
      chk("t5_oor_valid", {31'b0, rd_valid1}, 32'd1);
      wr(5'd16, 24'hDEADBE, 3'b111);
      wr(5'd31, 24'hBEEF01, 3'b111);
      swap_now();
      for (int a = 0; a < 16; a++) rd(5'(a));
      idle(2);

      // Reset while a swap is pending abandons it.
      clr(); swap_req = 1; step();
      do_reset();
      chk("t6_front_rst", {31'b0, front_sel1}, 32'd0);
      clr(); rd_frame_end = 1; step();
      chk("t6_no_swap", {31'b0, front_sel1}, 32'd0);
      idle(2);

      // Randomised traffic against the model, with occasional resets.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            wr_en        = 1'($urandom);
            wr_be        = 3'($urandom);
            wr_addr      = 5'($urandom_range(0, 31));
            wr_data      = 24'($urandom);
            rd_en        = 1'($urandom);
            rd_addr      = 5'($urandom_range(0, 31));
            swap_req     = ($urandom_range(0, 9) == 0);
            rd_frame_end = ($urandom_range(0, 7) == 0);
            step();
         end
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/framebuffer_pingpong_ram.md
Name: framebuffer_pingpong_ram

Overview:
- Parametrised, double-buffered (ping-pong) frame store for the output pipeline.
- Generalises the single-bank 24-bit pixel RAM: configurable width and depth, byte-lane write enables, selectable read latency, and a frame-swap handshake.
- The rasteriser writes the back bank while the display scan-out reads the front bank.
- Banks exchange roles only at a frame boundary, so scan-out never shows a partially drawn frame.

Parameters:
- DATA_W, 24, pixel word width in bits; must be a multiple of 8.
- DEPTH, 102400, words per bank (320x320 frame).
- ADDR_W, 17, address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2. The value 2 adds an output register.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- n_rst  in  1  asynchronous active-low reset.
- wr_en  in  1  write request to the back bank.
- wr_be  in  DATA_W/8  byte-lane write enables; bit i covers data bits [8i+7:8i].
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  high when writes are accepted.
- rd_en  in  1  read request from the front bank.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  marks rd_data valid for exactly one cycle per accepted read.
- rd_frame_end  in  1  pulse from scan-out: last pixel of the frame has been requested.
- swap_req  in  1  pulse from writer: back frame is complete.
- swap_ack  out  1  one-cycle pulse on the cycle after the banks exchange.
- front_sel  out  1  index of the current front bank.

Behaviour:
- Reset (n_rst low, asynchronous): front_sel=0, rd_data=0, rd_valid=0, swap_ack=0, wr_ready=1, swap FSM=IDLE, READ_LAT pipeline cleared.
  - Memory contents are not reset.
  - Reset asserted mid-swap abandons the swap: front_sel returns to 0 and no swap_ack is issued.
- Storage: 2*DEPTH words. The back bank is !front_sel; the front bank is front_sel.
- Write path:
  - A write is accepted when wr_en && wr_ready && wr_addr < DEPTH.
  - Only lanes with wr_be set are updated; wr_be=0 performs no change.
  - wr_addr >= DEPTH: the write is silently dropped and no other state is affected.
- Read path:
  - A read is accepted when rd_en is high. It samples rd_addr and front_sel at that edge.
  - READ_LAT=1: rd_data and rd_valid update on the next edge.
  - READ_LAT=2: rd_data and rd_valid update one edge later.
  - rd_addr >= DEPTH returns 0 with rd_valid still asserted.
  - When no read is issued, rd_data holds its last value and rd_valid=0.
  - Back-to-back reads give full throughput: one result per cycle.
- Swap FSM, states IDLE and PENDING:
  - IDLE, swap_req=1, rd_frame_end=0 -> PENDING; wr_ready drops to 0 on the next cycle.
  - IDLE, swap_req=1, rd_frame_end=1 -> swap this edge, stay IDLE.
  - PENDING, rd_frame_end=1 -> swap this edge, go to IDLE; wr_ready returns to 1 on the same edge.
  - PENDING: further swap_req pulses are ignored and do not queue.
  - rd_frame_end while IDLE with no swap_req: no action.
  - Swap means front_sel toggles, and swap_ack pulses high for exactly the following cycle.
- Simultaneous events:
  - A read accepted on the swap edge uses the old front bank.
  - Reads in flight complete from the bank they sampled.
  - A write on the swap edge from IDLE goes to the old back bank, i.e. into the frame being promoted. The writer owns that ordering.
- No read/write collision is possible: the two ports always address different banks.

Test Plan (DATA_W=24, DEPTH=16, ADDR_W=5, unless noted):
- Reset, then write 0xA1B2C3 to addr 3 with be=3'b111, swap_req together with rd_frame_end, then read addr 3 -> rd_data=0xA1B2C3, rd_valid high 1 cycle after rd_en, swap_ack high 1 cycle after the swap, front_sel=1.
- Back bank holds 0x112233 at addr 5; write 0xFFFFFF with be=3'b010 -> after a swap, the read returns 0x11FF33.
- swap_req alone -> wr_ready=0 next cycle and a write of 0x777777 to addr 0 is dropped. rd_frame_end 4 cycles later -> front_sel toggles, swap_ack pulses, wr_ready=1. The new front addr 0 keeps its prior value.
- READ_LAT=2: rd_en on 8 consecutive cycles, addrs 0..7 -> rd_valid high for 8 consecutive cycles starting 2 cycles later, with data in order.
- Read addr 20 -> rd_data=0, rd_valid=1. Write to addr 16 -> no bank contents change (check all 16 words).
- In PENDING, assert n_rst=0 for 1 cycle -> front_sel=0, wr_ready=1, no swap_ack. A later rd_frame_end causes no swap.
